// File: rtl/cop_sequencer.sv
// Program sequencer for the matrix coprocessor: holds a small instruction program and issues
// it one entry at a time over a valid/done handshake, with single-step and watchdog support.
module cop_sequencer #(
  parameter int unsigned IW      = 22,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned TIMEOUT = 1023,
  parameter logic [3:0]  END_OP  = 4'b0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_wdata,
  input  logic          start,
  input  logic          step_mode,
  input  logic          step,
  input  logic          abort,
  output logic [IW-1:0] cop_instr,
  output logic          cop_valid,
  input  logic          cop_done,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned   TW       = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);
  localparam logic [TW-1:0] TimerMax = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StStepW,
    StIssue,
    StWait,
    StDone,
    StErr
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [IW-1:0] cop_instr_q, cop_instr_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          cop_valid_q, cop_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [IW-1:0] mem_q [DEPTH];
  logic          prog_ok;

  // Program memory is only writable while no program is running.
  assign prog_ok = (state_q == StIdle) || (state_q == StDone) || (state_q == StErr);

  always_ff @(posedge clk) begin
    if (prog_we && prog_ok) begin
      mem_q[prog_addr] <= prog_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    timer_d = timer_q;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          pc_d    = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        ir_d    = mem_q[pc_q];
        state_d = StDecode;
      end
      StDecode: begin
        if (ir_q[3:0] == END_OP) begin
          state_d = StDone;
        end else if (step_mode) begin
          state_d = StStepW;
        end else begin
          state_d = StIssue;
        end
      end
      StStepW: begin
        if (step) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        // Completion takes priority over the watchdog in the same cycle.
        if (cop_done) begin
          if (pc_q == LastAddr) begin
            state_d = StDone;
          end else begin
            pc_d    = pc_q + AW'(1);
            state_d = StFetch;
          end
        end else if (timer_q == TimerMax) begin
          state_d = StErr;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (abort) begin
      state_d = StIdle;
      pc_d    = '0;
    end
  end

  // Status outputs are registered from the next state so they line up with their state cycle.
  always_comb begin
    cop_valid_d = (state_d == StIssue);
    cop_instr_d = (state_d == StIssue) ? ir_d : cop_instr_q;
    busy_d      = (state_d == StFetch) || (state_d == StDecode) || (state_d == StStepW) ||
                  (state_d == StIssue) || (state_d == StWait);
    done_d      = (state_d == StDone);
    err_d       = (state_d == StErr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ir_q        <= '0;
      cop_instr_q <= '0;
      pc_q        <= '0;
      timer_q     <= '0;
      cop_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      cop_instr_q <= cop_instr_d;
      pc_q        <= pc_d;
      timer_q     <= timer_d;
      cop_valid_q <= cop_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cop_instr = cop_instr_q;
  assign cop_valid = cop_valid_q;
  assign pc        = pc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
